spi_dac_writer: RTL and testbench

SPI_DAC_WRITER -- requirements
Module: spi_dac_writer

---
 rtl/spi_dac_pkg.sv | 21 ++
 rtl/spi_dac_writer_if.sv | 13 +
 rtl/spi_clk_div.sv | 35 +++
 rtl/spi_dac_writer.sv | 159 +++++++++++++++
 tb/tb_spi_dac_writer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_dac_pkg.sv
// Shared types and SPI mode constants for the SPI DAC writer.
package spi_dac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam int CPOL_IDLE_LOW        = 0;
  localparam int CPOL_IDLE_HIGH       = 1;
  localparam int CPHA_SAMPLE_LEADING  = 0;
  localparam int CPHA_SAMPLE_TRAILING = 1;

  function automatic int csel_width(input int n_cs);
    return (n_cs > 1) ? $clog2(n_cs) : 1;
  endfunction

endpackage

// File: rtl/spi_dac_writer_if.sv
// Frame request handshake between a producer and the SPI DAC writer.
interface spi_dac_writer_if #(
  parameter int DATA_W = 16,
  parameter int CSEL_W = 1
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic [CSEL_W-1:0] s_cs_sel;

  modport master (output s_valid, output s_data, output s_cs_sel, input s_ready);
  modport slave  (input s_valid, input s_data, input s_cs_sel, output s_ready);
endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one-cycle pulse every CLK_DIV enabled cycles.
module spi_clk_div #(
  parameter int CLK_DIV = 12
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);
  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign tick = en && (cnt_reg == CNT_LAST);

  // Counting restarts from zero whenever disabled so every phase begins aligned.
  always_comb begin
    cnt_next = cnt_reg;
    if (!en || tick) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end
endmodule

// File: rtl/spi_dac_writer.sv
// SPI DAC frame writer: accepts one word per handshake and shifts it out MSB first
// on the selected chip select, then holds all selects high for a minimum gap.
module spi_dac_writer
  import spi_dac_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 12,
  parameter int N_CS    = 1,
  parameter int CPOL    = 0,
  parameter int CPHA    = 1,
  parameter int CS_GAP  = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  spi_dac_writer_if.slave s_if,
  output logic            sclk,
  output logic            mosi,
  output logic [N_CS-1:0] cs_n,
  output logic            busy,
  output logic            done
);
  localparam int CSEL_W = csel_width(N_CS);
  localparam int BIT_W  = $clog2(2 * DATA_W + 1);
  localparam int GAP_W  = $clog2(CS_GAP + 1);
  localparam logic [BIT_W-1:0] LAST_EDGE = BIT_W'(2 * DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(CS_GAP - 1);
  localparam logic SCLK_IDLE    = (CPOL != CPOL_IDLE_LOW);
  localparam logic SAMPLE_TRAIL = (CPHA == CPHA_SAMPLE_TRAILING);

  state_t            state_reg, state_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [CSEL_W-1:0] sel_reg, sel_next;
  logic [BIT_W-1:0]  edge_reg, edge_next;
  logic [GAP_W-1:0]  gap_reg, gap_next;
  logic              sclk_reg, sclk_next;
  logic              mosi_reg, mosi_next;
  logic              done_reg, done_next;
  logic [N_CS-1:0]   cs_n_reg, cs_n_next;
  logic [N_CS-1:0]   cs_hit;
  logic              armed_reg;
  logic              tick, div_en, accept, in_frame_next, leading_edge, mosi_update;

  assign div_en = (state_reg == ST_SETUP) || (state_reg == ST_SHIFT) || (state_reg == ST_HOLD);
  assign s_if.s_ready = armed_reg && (state_reg == ST_IDLE);
  assign accept       = s_if.s_valid && s_if.s_ready;
  assign sel_next     = accept ? s_if.s_cs_sel : sel_reg;

  // edge_reg counts edges already made, so an even count means the next edge leads.
  assign leading_edge = ~edge_reg[0];
  assign mosi_update  = SAMPLE_TRAIL ? leading_edge
                                     : (!leading_edge && (edge_reg != LAST_EDGE));

  genvar gi;
  generate
    for (gi = 0; gi < N_CS; gi++) begin : g_cs_dec
      assign cs_hit[gi] = (sel_next == CSEL_W'(gi));
    end
  endgenerate

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (div_en),
    .tick    (tick)
  );

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    edge_next  = edge_reg;
    gap_next   = gap_reg;
    sclk_next  = sclk_reg;
    mosi_next  = mosi_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_SETUP;
          if (SAMPLE_TRAIL) begin
            shift_next = s_if.s_data;
          end else begin
            // Leading-edge sampling needs the MSB on the wire before the first edge.
            mosi_next  = s_if.s_data[DATA_W-1];
            shift_next = s_if.s_data << 1;
          end
        end
      end
      ST_SETUP: begin
        if (tick) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (tick) begin
          sclk_next = ~sclk_reg;
          edge_next = edge_reg + BIT_W'(1);
          if (mosi_update) begin
            mosi_next  = shift_reg[DATA_W-1];
            shift_next = shift_reg << 1;
          end
          if (edge_reg == LAST_EDGE) begin
            state_next = ST_HOLD;
            edge_next  = '0;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_next = ST_GAP;
          done_next  = 1'b1;
          mosi_next  = 1'b0;
          shift_next = '0;
        end
      end
      ST_GAP: begin
        if (gap_reg == GAP_LAST) begin
          state_next = ST_IDLE;
          gap_next   = '0;
        end else begin
          gap_next = gap_reg + GAP_W'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
    in_frame_next = (state_next == ST_SETUP) || (state_next == ST_SHIFT) ||
                    (state_next == ST_HOLD);
    cs_n_next = in_frame_next ? ~cs_hit : '1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= ST_IDLE;
      shift_reg <= '0;
      sel_reg   <= '0;
      edge_reg  <= '0;
      gap_reg   <= '0;
      sclk_reg  <= SCLK_IDLE;
      mosi_reg  <= 1'b0;
      done_reg  <= 1'b0;
      cs_n_reg  <= '1;
      armed_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      sel_reg   <= sel_next;
      edge_reg  <= edge_next;
      gap_reg   <= gap_next;
      sclk_reg  <= sclk_next;
      mosi_reg  <= mosi_next;
      done_reg  <= done_next;
      cs_n_reg  <= cs_n_next;
      armed_reg <= 1'b1;
    end
  end

  assign sclk = sclk_reg;
  assign mosi = mosi_reg;
  assign cs_n = cs_n_reg;
  assign done = done_reg;
  assign busy = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_spi_dac_writer.sv
// Directed bench for spi_dac_writer: four parameterisations, a vector table and
// hand-written sequences for back-to-back frames and mid-frame reset.
module tb_spi_dac_writer;
  logic clk;
  logic reset_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_dac_writer_if #(.DATA_W(16), .CSEL_W(1)) a_if ();
  spi_dac_writer_if #(.DATA_W(8),  .CSEL_W(1)) b_if ();
  spi_dac_writer_if #(.DATA_W(8),  .CSEL_W(2)) c_if ();
  spi_dac_writer_if #(.DATA_W(8),  .CSEL_W(2)) d_if ();

  logic a_sclk, a_mosi, a_busy, a_done;
  logic b_sclk, b_mosi, b_busy, b_done;
  logic c_sclk, c_mosi, c_busy, c_done;
  logic d_sclk, d_mosi, d_busy, d_done;
  logic [0:0] a_cs_n;
  logic [0:0] b_cs_n;
  logic [3:0] c_cs_n;
  logic [2:0] d_cs_n;

  spi_dac_writer u_a (
    .clk(clk), .reset_n(reset_n), .s_if(a_if), .sclk(a_sclk), .mosi(a_mosi),
    .cs_n(a_cs_n), .busy(a_busy), .done(a_done));

  spi_dac_writer #(.DATA_W(8), .CLK_DIV(1), .N_CS(1), .CPOL(1), .CPHA(0), .CS_GAP(4)) u_b (
    .clk(clk), .reset_n(reset_n), .s_if(b_if), .sclk(b_sclk), .mosi(b_mosi),
    .cs_n(b_cs_n), .busy(b_busy), .done(b_done));

  spi_dac_writer #(.DATA_W(8), .CLK_DIV(2), .N_CS(4), .CPOL(0), .CPHA(1), .CS_GAP(2)) u_c (
    .clk(clk), .reset_n(reset_n), .s_if(c_if), .sclk(c_sclk), .mosi(c_mosi),
    .cs_n(c_cs_n), .busy(c_busy), .done(c_done));

  spi_dac_writer #(.DATA_W(8), .CLK_DIV(2), .N_CS(3), .CPOL(0), .CPHA(1), .CS_GAP(2)) u_d (
    .clk(clk), .reset_n(reset_n), .s_if(d_if), .sclk(d_sclk), .mosi(d_mosi),
    .cs_n(d_cs_n), .busy(d_busy), .done(d_done));

  // Probe of whichever instance is under test, with chip selects padded to 8 bits.
  int         act;
  logic       m_sclk, m_mosi, m_busy, m_done, m_ready;
  logic [7:0] m_csn;

  always_comb begin
    m_sclk = 1'b0; m_mosi = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_ready = 1'b0; m_csn = 8'hFF;
    case (act)
      0: begin m_sclk = a_sclk; m_mosi = a_mosi; m_busy = a_busy; m_done = a_done;
               m_ready = a_if.s_ready; m_csn = {7'h7F, a_cs_n}; end
      1: begin m_sclk = b_sclk; m_mosi = b_mosi; m_busy = b_busy; m_done = b_done;
               m_ready = b_if.s_ready; m_csn = {7'h7F, b_cs_n}; end
      2: begin m_sclk = c_sclk; m_mosi = c_mosi; m_busy = c_busy; m_done = c_done;
               m_ready = c_if.s_ready; m_csn = {4'hF, c_cs_n}; end
      default: begin m_sclk = d_sclk; m_mosi = d_mosi; m_busy = d_busy; m_done = d_done;
               m_ready = d_if.s_ready; m_csn = {5'h1F, d_cs_n}; end
    endcase
  end

  typedef struct {
    int          dut;
    logic [31:0] data;
    logic [2:0]  sel;
    int          exp_low;    // cycles with some cs_n low
    int          exp_done;   // cycles from handshake cycle to done cycle
    logic [31:0] exp_bits;   // bits seen on sclk falling edges, first bit in the MSB
    logic [7:0]  exp_mask;   // which cs_n bits go low
    int          exp_nfall;
    logic        exp_idle;   // sclk idle level
    logic        chk_first;
    logic        exp_first;  // mosi in first cs-low cycle
  } vec_t;

  vec_t vecs[6];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    end
  endtask

  task automatic drive(input int dut, input logic v, input logic [31:0] d, input logic [2:0] s);
    case (dut)
      0: begin a_if.s_valid = v; a_if.s_data = d[15:0]; a_if.s_cs_sel = s[0]; end
      1: begin b_if.s_valid = v; b_if.s_data = d[7:0]; b_if.s_cs_sel = s[0]; end
      2: begin c_if.s_valid = v; c_if.s_data = d[7:0]; c_if.s_cs_sel = s[1:0]; end
      default: begin d_if.s_valid = v; d_if.s_data = d[7:0]; d_if.s_cs_sel = s[1:0]; end
    endcase
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (!m_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(name, m_ready, 1'b1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int t, t_done, low, nfall, ready_bad, busy_bad, multi_bad;
    logic [31:0] bits;
    logic [7:0]  lowmask;
    logic first_mosi, first_sclk, prev_sclk, prev_mosi, prev_low, cs_low, rise_ok, idle_ok;
    t_done = -1; low = 0; nfall = 0; ready_bad = 0; busy_bad = 0; multi_bad = 0;
    bits = '0; lowmask = '0; first_mosi = 1'b0; first_sclk = 1'b0; rise_ok = 1'b0;
    act = v.dut;
    @(negedge clk);
    check({tag, "_ready_before"}, m_ready, 1'b1);
    drive(v.dut, 1'b1, v.data, v.sel);
    prev_sclk = m_sclk; prev_mosi = m_mosi; prev_low = 1'b0;
    @(negedge clk);
    // Data changed right after acceptance must not reach the wire.
    drive(v.dut, 1'b0, ~v.data, 3'd7);
    t = 1;
    while (t_done < 0 && t < 2000) begin
      cs_low = (m_csn != 8'hFF);
      if (t == 1) begin first_mosi = m_mosi; first_sclk = m_sclk; end
      if (cs_low) low++;
      lowmask = lowmask | ~m_csn;
      if (m_busy && m_ready) ready_bad++;
      if (!m_busy) busy_bad++;
      if (!$onehot0(~m_csn)) multi_bad++;
      if (prev_sclk && !m_sclk) begin bits = {bits[30:0], prev_mosi}; nfall++; end
      if (m_done) begin
        t_done  = t;
        rise_ok = (m_csn == 8'hFF) && (prev_low == (v.exp_mask != 8'h00));
      end
      prev_sclk = m_sclk; prev_mosi = m_mosi; prev_low = cs_low;
      if (t_done < 0) begin @(negedge clk); t++; end
    end
    check({tag, "_done_time"}, t_done, v.exp_done);
    check({tag, "_cs_low_cycles"}, low, v.exp_low);
    check({tag, "_bits"}, bits, v.exp_bits);
    check({tag, "_nfall"}, nfall, v.exp_nfall);
    check({tag, "_cs_mask"}, lowmask, v.exp_mask);
    check({tag, "_done_at_cs_rise"}, rise_ok, 1'b1);
    check({tag, "_ready_while_busy"}, ready_bad, 0);
    check({tag, "_busy_drop"}, busy_bad, 0);
    check({tag, "_cs_multi"}, multi_bad, 0);
    check({tag, "_setup_sclk"}, first_sclk, v.exp_idle);
    if (v.chk_first) check({tag, "_setup_mosi"}, first_mosi, v.exp_first);
    @(negedge clk);
    idle_ok = (m_sclk == v.exp_idle) && !m_mosi && (m_csn == 8'hFF) && !m_done && m_busy;
    check({tag, "_gap_idle"}, idle_ok, 1'b1);
    wait_ready({tag, "_back_idle"});
    $display("%s dut=%0d data=0x%0h sel=%0d low=%0d done@%0d bits=0x%0h mask=0x%0h",
             tag, v.dut, v.data, v.sel, low, t_done, bits, lowmask);
  endtask

  initial begin
    int t, frame, ndone, edges, ready_bad;
    int fall_t[3];
    logic [31:0] fbits[3];
    logic prev_sclk, prev_mosi, prev_low, cs_low;
    vec_t post;

    vecs[0] = '{0, 32'hA5C3, 3'd0, 408, 409, 32'hA5C3, 8'h01, 16, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1, 32'h81,   3'd0, 18,  19,  32'h81,   8'h01, 8,  1'b1, 1'b1, 1'b1};
    vecs[2] = '{1, 32'h3C,   3'd0, 18,  19,  32'h3C,   8'h01, 8,  1'b1, 1'b1, 1'b0};
    vecs[3] = '{2, 32'h5A,   3'd2, 36,  37,  32'h5A,   8'h04, 8,  1'b0, 1'b0, 1'b0};
    vecs[4] = '{3, 32'hC3,   3'd3, 0,   37,  32'hC3,   8'h00, 8,  1'b0, 1'b0, 1'b0};
    vecs[5] = '{3, 32'h96,   3'd1, 36,  37,  32'h96,   8'h02, 8,  1'b0, 1'b0, 1'b0};

    act = 0;
    for (int i = 0; i < 4; i++) drive(i, 1'b0, 32'h0, 3'd0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a_sclk", a_sclk, 1'b0);
    check("rst_b_sclk", b_sclk, 1'b1);
    check("rst_a_mosi", a_mosi, 1'b0);
    check("rst_c_cs_n", c_cs_n, 4'hF);
    check("rst_busy", {a_busy, b_busy, c_busy, d_busy}, 4'h0);
    check("rst_done", {a_done, b_done, c_done, d_done}, 4'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {a_if.s_ready, b_if.s_ready, c_if.s_ready, d_if.s_ready}, 4'hF);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back frames with s_valid held; payload swapped once the first is taken.
    act = 0;
    @(negedge clk);
    drive(0, 1'b1, 32'h0001, 3'd0);
    frame = 0; ndone = 0; ready_bad = 0; t = 0;
    fall_t = '{0, 0, 0}; fbits = '{0, 0, 0};
    prev_sclk = m_sclk; prev_mosi = m_mosi; prev_low = 1'b0;
    while (ndone < 2 && t < 1500) begin
      @(negedge clk);
      t++;
      cs_low = (m_csn != 8'hFF);
      if (cs_low && !prev_low && frame < 2) begin
        frame++;
        fall_t[frame] = t;
        if (frame == 1) drive(0, 1'b1, 32'hFFFF, 3'd0);
      end
      if (cs_low && m_ready) ready_bad++;
      if (prev_sclk && !m_sclk) fbits[frame] = {fbits[frame][30:0], prev_mosi};
      if (m_done) begin
        ndone++;
        if (ndone == 2) drive(0, 1'b0, 32'h0, 3'd0);
      end
      prev_sclk = m_sclk; prev_mosi = m_mosi; prev_low = cs_low;
    end
    check("b2b_frames_done", ndone, 2);
    check("b2b_fall_spacing", fall_t[2] - fall_t[1], 413);
    check("b2b_bits_first", fbits[1], 32'h0001);
    check("b2b_bits_second", fbits[2], 32'hFFFF);
    check("b2b_ready_low", ready_bad, 0);
    $display("b2b falls at %0d and %0d, bits 0x%0h 0x%0h",
             fall_t[1], fall_t[2], fbits[1], fbits[2]);
    wait_ready("b2b_back_idle");

    // Reset asserted between clock edges just after the 8th sclk edge.
    @(negedge clk);
    drive(0, 1'b1, 32'h1234, 3'd0);
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 3'd0);
    edges = 0; t = 0;
    prev_sclk = m_sclk;
    while (edges < 8 && t < 1000) begin
      @(negedge clk);
      t++;
      if (m_sclk != prev_sclk) edges++;
      prev_sclk = m_sclk;
    end
    check("rst_mid_edges", edges, 8);
    check("rst_mid_cs_low", a_cs_n, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_sclk", a_sclk, 1'b0);
    check("rst_mid_mosi", a_mosi, 1'b0);
    check("rst_mid_cs_n", a_cs_n, 1'b1);
    check("rst_mid_busy", a_busy, 1'b0);
    check("rst_mid_done", a_done, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_mid_no_done", a_done, 1'b0);
    $display("mid-frame reset after %0d sclk edges", edges);

    post = '{0, 32'h0F0F, 3'd0, 408, 409, 32'h0F0F, 8'h01, 16, 1'b0, 1'b0, 1'b0};
    run_vec(post, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
